// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle for the shared bitwise logic unit: two requesters,
// one result port and the completed-operation counter.
interface logic_unit_arbiter_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
);
  logic             RQ0_VALID;
  logic             RQ0_READY;
  logic [WIDTH-1:0] RQ0_A;
  logic [WIDTH-1:0] RQ0_B;
  logic [1:0]       RQ0_OP;

  logic             RQ1_VALID;
  logic             RQ1_READY;
  logic [WIDTH-1:0] RQ1_A;
  logic [WIDTH-1:0] RQ1_B;
  logic [1:0]       RQ1_OP;

  logic             RES_VALID;
  logic             RES_READY;
  logic [WIDTH-1:0] RES_DATA;
  logic             RES_SRC;
  logic             RES_ZERO;

  logic [CNT_W-1:0] OPS_DONE;

  modport slave (
    input  RQ0_VALID, RQ0_A, RQ0_B, RQ0_OP,
    output RQ0_READY,
    input  RQ1_VALID, RQ1_A, RQ1_B, RQ1_OP,
    output RQ1_READY,
    output RES_VALID, RES_DATA, RES_SRC, RES_ZERO,
    input  RES_READY,
    output OPS_DONE
  );

  modport master (
    output RQ0_VALID, RQ0_A, RQ0_B, RQ0_OP,
    input  RQ0_READY,
    output RQ1_VALID, RQ1_A, RQ1_B, RQ1_OP,
    input  RQ1_READY,
    input  RES_VALID, RES_DATA, RES_SRC, RES_ZERO,
    output RES_READY,
    input  OPS_DONE
  );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter in front of a shared 32-bit AND/OR/XOR/ANDN unit with a
// registered valid/ready result port and a saturating completion counter.
module logic_unit_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  logic_unit_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             last_gnt_q, last_gnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic             src_q, src_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_src_q, res_src_d;
  logic             res_zero_q, res_zero_d;
  logic [CNT_W-1:0] ops_done_q, ops_done_d;

  logic             any_valid_c;
  logic             winner_c;
  logic             rq0_ready_c;
  logic             rq1_ready_c;
  logic [WIDTH-1:0] alu_c;

  // On contention the requester that did not win last time gets the grant.
  assign any_valid_c = bus.RQ0_VALID | bus.RQ1_VALID;
  assign winner_c    = (bus.RQ0_VALID & bus.RQ1_VALID) ? ~last_gnt_q : bus.RQ1_VALID;

  always_comb begin
    unique case (op_q)
      2'b00:   alu_c = a_q & b_q;
      2'b01:   alu_c = a_q | b_q;
      2'b10:   alu_c = a_q ^ b_q;
      default: alu_c = a_q & ~b_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    src_d       = src_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_src_d   = res_src_q;
    res_zero_d  = res_zero_q;
    ops_done_d  = ops_done_q;
    rq0_ready_c = 1'b0;
    rq1_ready_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (any_valid_c) begin
          rq0_ready_c = ~winner_c;
          rq1_ready_c = winner_c;
          a_d         = winner_c ? bus.RQ1_A  : bus.RQ0_A;
          b_d         = winner_c ? bus.RQ1_B  : bus.RQ0_B;
          op_d        = winner_c ? bus.RQ1_OP : bus.RQ0_OP;
          src_d       = winner_c;
          last_gnt_d  = winner_c;
          state_d     = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_data_d  = alu_c;
        res_zero_d  = (alu_c == '0);
        res_src_d   = src_q;
        res_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (bus.RES_READY) begin
          res_valid_d = 1'b0;
          if (ops_done_q != '1) begin
            ops_done_d = ops_done_q + CNT_W'(1);
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset discards any in-flight operation; LAST_GNT=1 lets requester 0 win first.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      last_gnt_q  <= 1'b1;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 2'b00;
      src_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_src_q   <= 1'b0;
      res_zero_q  <= 1'b0;
      ops_done_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      src_q       <= src_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_src_q   <= res_src_d;
      res_zero_q  <= res_zero_d;
      ops_done_q  <= ops_done_d;
    end
  end

  assign bus.RQ0_READY = rq0_ready_c;
  assign bus.RQ1_READY = rq1_ready_c;
  assign bus.RES_VALID = res_valid_q;
  assign bus.RES_DATA  = res_data_q;
  assign bus.RES_SRC   = res_src_q;
  assign bus.RES_ZERO  = res_zero_q;
  assign bus.OPS_DONE  = ops_done_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter; a second instance with CNT_W=2 shares
// the same stimulus to exercise counter saturation.
module tb_logic_unit_arbiter;

  logic CLK;
  logic RESET;

  logic_unit_arbiter_if #(.WIDTH(32), .CNT_W(16)) bus ();
  logic_unit_arbiter_if #(.WIDTH(32), .CNT_W(2))  bus_s ();

  logic_unit_arbiter #(.WIDTH(32), .CNT_W(16)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  logic_unit_arbiter #(.WIDTH(32), .CNT_W(2)) dut_s (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus_s)
  );

  assign bus_s.RQ0_VALID = bus.RQ0_VALID;
  assign bus_s.RQ0_A     = bus.RQ0_A;
  assign bus_s.RQ0_B     = bus.RQ0_B;
  assign bus_s.RQ0_OP    = bus.RQ0_OP;
  assign bus_s.RQ1_VALID = bus.RQ1_VALID;
  assign bus_s.RQ1_A     = bus.RQ1_A;
  assign bus_s.RQ1_B     = bus.RQ1_B;
  assign bus_s.RQ1_OP    = bus.RQ1_OP;
  assign bus_s.RES_READY = bus.RES_READY;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        src;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] exp;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[9];
  int   checks = 0;
  int   errors = 0;
  int   exp_ops = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic src, input logic v, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] op);
    if (src == 1'b0) begin
      bus.RQ0_VALID = v; bus.RQ0_A = a; bus.RQ0_B = b; bus.RQ0_OP = op;
    end else begin
      bus.RQ1_VALID = v; bus.RQ1_A = a; bus.RQ1_B = b; bus.RQ1_OP = op;
    end
  endtask

  task automatic chk_counters(input string name);
    chk({name, "_ops_done"}, 32'(bus.OPS_DONE), 32'(exp_ops));
    chk({name, "_ops_done_sat"}, 32'(bus_s.OPS_DONE), (exp_ops > 3) ? 32'd3 : 32'(exp_ops));
  endtask

  // One uncontended operation with exact latency checks and a one-cycle handshake.
  task automatic run_op(input vec_t v);
    @(negedge CLK);
    drive(v.src, 1'b1, v.a, v.b, v.op);
    #1;
    chk("rq_ready", v.src ? 32'(bus.RQ1_READY) : 32'(bus.RQ0_READY), 32'd1);
    chk("other_ready", v.src ? 32'(bus.RQ0_READY) : 32'(bus.RQ1_READY), 32'd0);
    @(negedge CLK);
    drive(v.src, 1'b0, ~v.a, ~v.b, ~v.op);
    chk("exec_res_valid", 32'(bus.RES_VALID), 32'd0);
    @(negedge CLK);
    chk("resp_valid", 32'(bus.RES_VALID), 32'd1);
    chk("resp_data", bus.RES_DATA, v.exp);
    chk("resp_src", 32'(bus.RES_SRC), 32'(v.src));
    chk("resp_zero", 32'(bus.RES_ZERO), 32'(v.exp_zero));
    bus.RES_READY = 1'b1;
    exp_ops++;
    @(negedge CLK);
    bus.RES_READY = 1'b0;
    chk("post_hs_valid", 32'(bus.RES_VALID), 32'd0);
    chk_counters("post_hs");
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'hF0F0_FFFF, 32'h0FF0_1234, 2'b00, 32'h00F0_1234, 1'b0};
    vecs[1] = '{1'b1, 32'hAAAA_5555, 32'hFFFF_0000, 2'b00, 32'hAAAA_0000, 1'b0};
    vecs[2] = '{1'b0, 32'hAAAA_5555, 32'hFFFF_0000, 2'b01, 32'hFFFF_5555, 1'b0};
    vecs[3] = '{1'b1, 32'hAAAA_5555, 32'hFFFF_0000, 2'b10, 32'h5555_5555, 1'b0};
    vecs[4] = '{1'b0, 32'hAAAA_5555, 32'hFFFF_0000, 2'b11, 32'h0000_5555, 1'b0};
    vecs[5] = '{1'b1, 32'h1234_5678, 32'h0000_0000, 2'b00, 32'h0000_0000, 1'b1};
    vecs[6] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 32'h0000_0000, 1'b1};
    vecs[7] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 32'h0000_0000, 1'b1};
    vecs[8] = '{1'b0, 32'h8000_0001, 32'h0000_0000, 2'b01, 32'h8000_0001, 1'b0};

    RESET = 1'b1;
    bus.RES_READY = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 2'b00);
    repeat (2) @(negedge CLK);
    chk("rst_res_valid", 32'(bus.RES_VALID), 32'd0);
    chk("rst_res_data", bus.RES_DATA, 32'd0);
    chk("rst_res_src", 32'(bus.RES_SRC), 32'd0);
    chk("rst_res_zero", 32'(bus.RES_ZERO), 32'd0);
    chk_counters("rst");
    RESET = 1'b0;

    for (int i = 0; i < 9; i++) run_op(vecs[i]);

    // Backpressure: stall 10 cycles in RESP while requester 1 waits.
    @(negedge CLK);
    drive(1'b0, 1'b1, 32'h0000_FFFF, 32'h00FF_00FF, 2'b00);
    #1;
    chk("bp_rq0_ready", 32'(bus.RQ0_READY), 32'd1);
    @(negedge CLK);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    drive(1'b1, 1'b1, 32'h0F0F_0F0F, 32'h0000_0000, 2'b01);
    #1;
    chk("bp_exec_readys", {30'd0, bus.RQ0_READY, bus.RQ1_READY}, 32'd0);
    @(negedge CLK);
    chk("bp_resp_valid", 32'(bus.RES_VALID), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      #1;
      chk("bp_stall_valid", 32'(bus.RES_VALID), 32'd1);
      chk("bp_stall_data", bus.RES_DATA, 32'h0000_00FF);
      chk("bp_stall_readys", {30'd0, bus.RQ0_READY, bus.RQ1_READY}, 32'd0);
    end
    chk_counters("bp_stall");
    bus.RES_READY = 1'b1;
    exp_ops++;
    @(negedge CLK);
    #1;
    chk("bp_release_valid", 32'(bus.RES_VALID), 32'd0);
    chk_counters("bp_release");
    chk("bp_next_rq1_ready", 32'(bus.RQ1_READY), 32'd1);
    @(negedge CLK);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 2'b00);
    chk_counters("bp_one_hs");
    @(negedge CLK);
    chk("bp2_valid", 32'(bus.RES_VALID), 32'd1);
    chk("bp2_data", bus.RES_DATA, 32'h0F0F_0F0F);
    chk("bp2_src", 32'(bus.RES_SRC), 32'd1);
    exp_ops++;
    @(negedge CLK);
    bus.RES_READY = 1'b0;
    chk("bp2_done_valid", 32'(bus.RES_VALID), 32'd0);
    chk_counters("bp2_done");

    // Reset during EXEC drops the operation without a response.
    @(negedge CLK);
    drive(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 2'b00);
    #1;
    chk("rmid_rq1_ready", 32'(bus.RQ1_READY), 32'd1);
    @(negedge CLK);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 2'b00);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    exp_ops = 0;
    chk("rmid_valid", 32'(bus.RES_VALID), 32'd0);
    chk_counters("rmid");
    @(negedge CLK);
    chk("rmid_no_resp", 32'(bus.RES_VALID), 32'd0);

    // Contention with RES_READY held high: grants alternate starting with 0.
    bus.RES_READY = 1'b1;
    drive(1'b0, 1'b1, 32'hFFFF_0000, 32'h00FF_00FF, 2'b10);
    drive(1'b1, 1'b1, 32'h1234_5678, 32'hF0F0_F0F0, 2'b01);
    for (int i = 0; i < 4; i++) begin
      logic g;
      g = (i % 2 == 1);
      #1;
      chk("cont_ready0", 32'(bus.RQ0_READY), g ? 32'd0 : 32'd1);
      chk("cont_ready1", 32'(bus.RQ1_READY), g ? 32'd1 : 32'd0);
      @(negedge CLK);
      #1;
      chk("cont_exec_readys", {30'd0, bus.RQ0_READY, bus.RQ1_READY}, 32'd0);
      chk("cont_exec_valid", 32'(bus.RES_VALID), 32'd0);
      @(negedge CLK);
      chk("cont_resp_valid", 32'(bus.RES_VALID), 32'd1);
      chk("cont_resp_src", 32'(bus.RES_SRC), 32'(g));
      chk("cont_resp_data", bus.RES_DATA, g ? 32'hF2F4_F6F8 : 32'hFF00_00FF);
      exp_ops++;
      @(negedge CLK);
      chk("cont_idle_valid", 32'(bus.RES_VALID), 32'd0);
      chk_counters("cont");
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 2'b00);
    bus.RES_READY = 1'b0;
    repeat (2) @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
